// File: rtl/lvl_pkg.sv
// Shared definitions for the backtrack-level controller: level-state field
// layout, result codes and FSM encoding.
package lvl_pkg;
  localparam int HAS_BKT_BIT = 0;
  localparam int DCD_BIN_LSB = 1;
  localparam int DCD_BIN_MSB = 10;

  typedef enum logic [1:0] {
    ST_LOCAL  = 2'd0,
    ST_REMOTE = 2'd1,
    ST_UNSAT  = 2'd2,
    ST_RANGE  = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SCAN      = 3'd1,
    S_APPLY     = 3'd2,
    S_LOAD_WAIT = 3'd3,
    S_DONE      = 3'd4
  } state_e;
endpackage

// File: rtl/lvl_state_sel.sv
// Combinational level-index to level-state slice mux (levels are 1-based).
// Any index outside 1..NUM_LVLS reads as "already backtracked, bin 0".
module lvl_state_sel
  import lvl_pkg::*;
#(
  parameter int NUM_LVLS         = 4,
  parameter int WIDTH_LVL_STATES = 11,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_BIN        = 10
) (
  input  logic [WIDTH_LVL-1:0]                 idx,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states,
  output logic                                 has_bkt,
  output logic [WIDTH_BIN-1:0]                 dcd_bin
);
  always_comb begin
    has_bkt = 1'b1;
    dcd_bin = '0;
    for (int j = 1; j <= NUM_LVLS; j++) begin
      if (idx == WIDTH_LVL'(j)) begin
        has_bkt = lvl_states[WIDTH_LVL_STATES*(j-1) + HAS_BKT_BIT];
        dcd_bin = lvl_states[WIDTH_LVL_STATES*(j-1) + DCD_BIN_LSB +: WIDTH_BIN];
      end
    end
  end
endmodule

// File: rtl/lvl_bkt_ctrl.sv
// Finds the highest level not yet backtracked, pulses apply_bkt to the level
// array, and requests a bin switch when that level lives in another bin.
module lvl_bkt_ctrl
  import lvl_pkg::*;
#(
  parameter int NUM_LVLS         = 4,
  parameter int WIDTH_LVL_STATES = 11,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_BIN        = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [WIDTH_LVL-1:0]                 max_lvl_i,
  input  logic [WIDTH_BIN-1:0]                 cur_bin_num_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
  output logic                                 busy_o,
  output logic                                 apply_bkt_o,
  output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
  output logic [WIDTH_BIN-1:0]                 bkt_bin_o,
  output logic                                 load_req_o,
  input  logic                                 load_ack_i,
  output logic                                 done_o,
  output logic [1:0]                           status_o
);
  state_e               state, nxt_state;
  logic [WIDTH_LVL-1:0] idx, nxt_idx;
  logic [WIDTH_BIN-1:0] cur_bin_q, nxt_cur_bin;
  logic [WIDTH_LVL-1:0] bkt_lvl_q, nxt_bkt_lvl;
  logic [WIDTH_BIN-1:0] bkt_bin_q, nxt_bkt_bin;
  status_e              status_q, nxt_status;
  logic                 sel_has_bkt;
  logic [WIDTH_BIN-1:0] sel_dcd_bin;

  lvl_state_sel #(
    .NUM_LVLS        (NUM_LVLS),
    .WIDTH_LVL_STATES(WIDTH_LVL_STATES),
    .WIDTH_LVL       (WIDTH_LVL),
    .WIDTH_BIN       (WIDTH_BIN)
  ) u_sel (
    .idx       (idx),
    .lvl_states(lvl_states_i),
    .has_bkt   (sel_has_bkt),
    .dcd_bin   (sel_dcd_bin)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      cur_bin_q <= '0;
      bkt_lvl_q <= '0;
      bkt_bin_q <= '0;
      status_q  <= ST_LOCAL;
    end else begin
      state     <= nxt_state;
      idx       <= nxt_idx;
      cur_bin_q <= nxt_cur_bin;
      bkt_lvl_q <= nxt_bkt_lvl;
      bkt_bin_q <= nxt_bkt_bin;
      status_q  <= nxt_status;
    end
  end

  always_comb begin
    nxt_state   = state;
    nxt_idx     = idx;
    nxt_cur_bin = cur_bin_q;
    nxt_bkt_lvl = bkt_lvl_q;
    nxt_bkt_bin = bkt_bin_q;
    nxt_status  = status_q;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          nxt_cur_bin = cur_bin_num_i;
          nxt_bkt_lvl = '0;
          nxt_bkt_bin = '0;
          if (max_lvl_i == '0) begin
            nxt_status = ST_UNSAT;
            nxt_state  = S_DONE;
          end else if (max_lvl_i > WIDTH_LVL'(NUM_LVLS)) begin
            nxt_status = ST_RANGE;
            nxt_state  = S_DONE;
          end else begin
            nxt_idx   = max_lvl_i;
            nxt_state = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        // Level 1 ends the scan, so idx never decrements to 0.
        if (!sel_has_bkt) begin
          nxt_bkt_lvl = idx;
          nxt_bkt_bin = sel_dcd_bin;
          nxt_state   = S_APPLY;
        end else if (idx == WIDTH_LVL'(1)) begin
          nxt_status = ST_UNSAT;
          nxt_state  = S_DONE;
        end else begin
          nxt_idx = idx - WIDTH_LVL'(1);
        end
      end
      S_APPLY: begin
        if (bkt_bin_q == cur_bin_q) begin
          nxt_status = ST_LOCAL;
          nxt_state  = S_DONE;
        end else begin
          nxt_state = S_LOAD_WAIT;
        end
      end
      S_LOAD_WAIT: begin
        if (load_ack_i) begin
          nxt_status = ST_REMOTE;
          nxt_state  = S_DONE;
        end
      end
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  assign busy_o      = (state != S_IDLE);
  assign apply_bkt_o = (state == S_APPLY);
  assign load_req_o  = (state == S_LOAD_WAIT);
  assign done_o      = (state == S_DONE);
  assign bkt_lvl_o   = bkt_lvl_q;
  assign bkt_bin_o   = bkt_bin_q;
  assign status_o    = status_q;
endmodule

// File: doc/lvl_bkt_ctrl.md
Name: lvl_bkt_ctrl

Overview:
- Sequences the find-backtrack-level and apply-backtrack operations over a Sat Engine's lvl_state array.
- On request, scans the per-level states downward from max_lvl and selects the highest level whose has_bkt is clear.
- Pulses apply_bkt to the array, then requests a bin switch when that level was decided in a bin other than the current one.
- Sits between the engine's top control FSM and the lvl_state array; holds off array writes while busy.

Parameters:
- NUM_LVLS, 4, number of levels held in the array (local levels 1..NUM_LVLS).
- WIDTH_LVL_STATES, 11, bits per level state: [10:1] dcd_bin, [0] has_bkt.
- WIDTH_LVL, 16, width of level numbers.
- WIDTH_BIN, 10, width of bin numbers.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- start_i  in  1  backtrack-search request; accepted only in IDLE.
- max_lvl_i  in  WIDTH_LVL  highest assigned level; sampled at start.
- cur_bin_num_i  in  WIDTH_BIN  bin currently loaded; sampled at start.
- lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS  array state; level j (1-based) at bits [11j-1:11(j-1)].
- busy_o  out  1  high in every state except IDLE; the array must not take wr_states while high.
- apply_bkt_o  out  1  one-cycle pulse commanding the array to backtrack.
- bkt_lvl_o  out  WIDTH_LVL  selected level; valid from APPLY until the next start.
- bkt_bin_o  out  WIDTH_BIN  dcd_bin of the selected level; valid as for bkt_lvl_o.
- load_req_o  out  1  bin-switch request; held until acknowledged.
- load_ack_i  in  1  bin loader acknowledge.
- done_o  out  1  one-cycle completion pulse.
- status_o  out  2  result, valid with done_o and held after: 0 local, 1 remote (bin switched), 2 unsat, 3 range error.

Behaviour:
- Reset (rst=0 at a clk edge) forces IDLE; all outputs, the scan index and the captured registers go to 0. This holds mid-operation, including an outstanding load_req_o, which is dropped without waiting for ack.
- FSM states: IDLE, SCAN, APPLY, LOAD_WAIT, DONE.
- IDLE, on start_i=1: capture max_lvl_i and cur_bin_num_i, then branch:
  - max_lvl_i==0 -> DONE with status 2.
  - max_lvl_i>NUM_LVLS -> DONE with status 3.
  - otherwise -> SCAN with idx=max_lvl_i.
- SCAN: one level per cycle through the sub-module selector.
  - has_bkt[idx]==0: latch bkt_lvl=idx and bkt_bin=dcd_bin[idx] -> APPLY.
  - has_bkt[idx]==1 and idx==1 -> DONE with status 2.
  - otherwise idx<=idx-1.
- APPLY: apply_bkt_o=1 for exactly this cycle. If bkt_bin==captured cur_bin -> DONE with status 0; else -> LOAD_WAIT.
- LOAD_WAIT: load_req_o=1 with bkt_bin_o stable. On load_ack_i=1 -> DONE with status 1; load_req_o drops the next cycle. An ack asserted in the same cycle load_req_o first rises is accepted.
- DONE: done_o=1 for one cycle -> IDLE. busy_o falls with the return to IDLE.
- start_i while busy is ignored, not queued. load_ack_i outside LOAD_WAIT is ignored.
- Latency, local hit at level f: start cycle 0, done_o at cycle (max-f)+3.
- Latency, unsat: done_o at cycle max+1.
- Latency, max==0 or range error: done_o at cycle 1.
- lvl_states_i is sampled combinationally each SCAN cycle. The array is stable because busy_o blocks writes.
- Arithmetic: idx is WIDTH_LVL wide with no wrap; idx==1 terminates the scan before any decrement to 0.

Decomposition:
- Shared package lvl_pkg:
  - field offsets: HAS_BKT_BIT=0, DCD_BIN_LSB=1, DCD_BIN_MSB=10.
  - status codes: ST_LOCAL, ST_REMOTE, ST_UNSAT, ST_RANGE.
  - FSM state encoding.
- One sub-module, lvl_state_sel: combinational index-to-slice mux returning has_bkt and dcd_bin for level idx; out-of-range idx returns has_bkt=1, dcd_bin=0.

Test Plan:
- NUM_LVLS=4, cur_bin=5, has_bkt L4..L1=1,1,0,0, all bins 5, max=4 -> SCAN cycles 1-3; apply_bkt_o at cycle 4 with bkt_lvl_o=2; done_o at cycle 5, status 0, bkt_bin_o=5; no load_req_o.
- max=3, L3 has_bkt=0, dcd_bin=2, cur=5 -> apply at cycle 2; load_req_o high from cycle 3 with bkt_bin_o=2; load_ack_i at cycle 6 -> done_o at cycle 7, status 1; load_req_o low at cycle 7.
- All has_bkt=1, max=4 -> four SCAN cycles, done_o at cycle 5, status 2, apply_bkt_o never high.
- max=0 -> done_o at cycle 1, status 2. max=7 -> done_o at cycle 1, status 3. Both with no SCAN cycles.
- start_i re-pulsed at cycle 2 of a scan -> ignored, exactly one done_o.
- Same setup, rst=0 at cycle 2 -> from cycle 3 busy_o=0, all outputs 0; a fresh start completes normally.
- rst=0 during LOAD_WAIT -> load_req_o=0 the next cycle.
